mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 142 ++++++++++++++
 tb/tb_mdu_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential RV32M multiply/divide unit
// Shift-add multiply and restoring divide on operand magnitudes, signs fixed up in FIX.
module mdu_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            opb5,
   input  logic            funct7b0,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            ready,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [XLEN-1:0] LAST_STEP = XLEN'(XLEN - 1);
   localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state, state_nx;
   logic [2:0]          op_q;
   logic                neg_a_q, neg_b_q;
   logic [XLEN-1:0]     dvsr_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     cnt_q;

   logic                is_m, can_go, accept;
   logic                a_sgn, b_sgn, neg_a, neg_b;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic                div_zero, div_ovf, special;
   logic [XLEN-1:0]     special_res;
   logic [XLEN:0]       mul_sum, div_trial;
   logic [2*XLEN-1:0]   mul_nx, div_nx, prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

   // Operand decode and the divide special cases that bypass CALC
   always_comb begin
      is_m     = opb5 & funct7b0;
      can_go   = (state == IDLE) & start & ~flush;
      accept   = can_go & is_m;
      a_sgn    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
      b_sgn    = funct3[2] ? ~funct3[0] : ~funct3[1];
      neg_a    = a_sgn & a[XLEN-1];
      neg_b    = b_sgn & b[XLEN-1];
      mag_a    = neg_a ? (~a + 1'b1) : a;
      mag_b    = neg_b ? (~b + 1'b1) : b;
      div_zero = funct3[2] & (b == '0);
      div_ovf  = funct3[2] & ~funct3[0] & (a == MOST_NEG) & (&b);
      special  = div_zero | div_ovf;
      if (div_zero)
         special_res = funct3[1] ? a : '1;
      else
         special_res = funct3[1] ? '0 : a;
   end

   // acc_q holds {upper product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
      mul_nx    = {mul_sum, acc_q[XLEN-1:1]};
      div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, dvsr_q};
      if (div_trial[XLEN])
         div_nx = {acc_q[2*XLEN-2:0], 1'b0};
      else
         div_nx = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   end

   always_comb begin
      prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
      quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_fix  = neg_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         3'b000:                 fix_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res = quo_fix;
         default:                fix_res = rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush)
         state_nx = IDLE;
      else begin
         case (state)
            IDLE: if (accept) state_nx = special ? DONE : CALC;
            CALC: if (cnt_q == LAST_STEP) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      ready = (state == IDLE);
      done  = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         dvsr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         result  <= '0;
         illegal <= 1'b0;
      end else begin
         illegal <= can_go & ~is_m;
         if (accept) begin
            op_q    <= funct3;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            dvsr_q  <= funct3[2] ? mag_b : mag_a;
            acc_q   <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            cnt_q   <= '0;
            if (special)
               result <= special_res;
         end else if (state == CALC && !flush) begin
            acc_q <= op_q[2] ? div_nx : mul_nx;
            cnt_q <= cnt_q + 1'b1;
         end else if (state == FIX && !flush) begin
            result <= fix_res;
         end
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        opb5 = 1'b1;
   logic        funct7b0 = 1'b1;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        ready, done, illegal;
   logic [31:0] result;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   logic        done_prev = 1'b0;

   mdu_seq #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .opb5(opb5),
      .funct7b0(funct7b0), .funct3(funct3), .a(a), .b(b), .flush(flush),
      .ready(ready), .done(done), .result(result), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (reset_n) begin
         if (done) begin
            check("done_not_back_to_back", {31'b0, done_prev}, 32'd0);
            if (exp_q.size() == 0)
               check("unexpected_done", 32'd1, 32'd0);
            else
               check("result", result, exp_q.pop_front());
         end
         done_prev = done;
      end else
         done_prev = 1'b0;
   end

   task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp, input int exp_lat);
      int  lat;
      int  wait_cnt;
      bit  ready_ok;
      wait_cnt = 0;
      while (!ready && wait_cnt < 100) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      if (!ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
      start = 1'b1; opb5 = 1'b1; funct7b0 = 1'b1; funct3 = f3; a = va; b = vb;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      ready_ok = 1'b1;
      while (!done && lat < 200) begin
         if (ready) ready_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (ready) ready_ok = 1'b0;
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_busy"}, {31'b0, ready_ok}, 32'd1);
   endtask

   initial begin
      #12;
      check("reset_ready", {31'b0, ready}, 32'd1);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_illegal", {31'b0, illegal}, 32'd0);
      check("reset_result", result, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      do_op("mul_neg",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      do_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      do_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34);
      do_op("div_neg",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
      do_op("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
      do_op("divu",       3'b101, 32'd100,      32'd7,        32'd14,       34);
      do_op("remu",       3'b111, 32'd100,      32'd7,        32'd2,        34);
      do_op("divu_zero",  3'b101, 32'h1234,     32'd0,        32'hFFFF_FFFF, 1);
      do_op("rem_zero",   3'b110, 32'h1234,     32'd0,        32'h1234,     1);
      do_op("div_zero",   3'b100, 32'h1234,     32'd0,        32'hFFFF_FFFF, 1);
      do_op("remu_zero",  3'b111, 32'd5,        32'd0,        32'd5,        1);
      do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       1);
      do_op("div_minby1", 3'b100, 32'h8000_0000, 32'd1,        32'h8000_0000, 34);
      do_op("rem_negdiv", 3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,        34);

      // Flush mid-calculation; a start while busy must not raise illegal
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'd9;
      @(posedge clk); #1;
      start = 1'b1; funct7b0 = 1'b0;
      @(posedge clk); #1;
      check("busy_start_no_illegal", {31'b0, illegal}, 32'd0);
      start = 1'b0; funct7b0 = 1'b1;
      repeat (7) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_ready", {31'b0, ready}, 32'd1);
      check("flush_result_held", result, 32'd1);
      repeat (40) @(posedge clk);
      #1;
      check("flush_result_still", result, 32'd1);
      do_op("mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 34);

      // Asynchronous reset in the middle of CALC
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'b000; a = 32'd11; b = 32'd13;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("midrst_ready", {31'b0, ready}, 32'd1);
      check("midrst_done", {31'b0, done}, 32'd0);
      check("midrst_illegal", {31'b0, illegal}, 32'd0);
      check("midrst_result", result, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("post_rst_result", result, 32'd0);

      // Rejected start: one-cycle illegal, no done
      start = 1'b1; funct7b0 = 1'b0; funct3 = 3'b000; a = 32'd2; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; funct7b0 = 1'b1;
      check("illegal_pulse", {31'b0, illegal}, 32'd1);
      check("illegal_ready", {31'b0, ready}, 32'd1);
      @(posedge clk); #1;
      check("illegal_single", {31'b0, illegal}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("illegal_no_result", result, 32'd0);

      do_op("mul_shift", 3'b000, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 34);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
